zapper_hit_detect: RTL and testbench
====================================

ZAPPER_HIT_DETECT -- requirements
Module: zapper_hit_detect

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, trigger stable time in clk cycles (10 ms at 25 MHz).
REQ-002 Parameter LIGHT_MIN, default 64, minimum lit-pixel count in white frame for a hit.
REQ-003 Parameter DARK_MAX, default 16, maximum lit-pixel count allowed in black frame.
REQ-004 clk  input  1  pixel clock; row/col advance one pixel per cycle; the block uses one clock only.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 trigger_raw  input  1  zapper trigger, asynchronous, active-high.
REQ-007 light_n  input  1  zapper photodiode, asynchronous, active-low (0 = light seen).
REQ-008 valid  input  1  display-active flag from the VGA timing block.
REQ-009 row  input  10  current scan row.
REQ-010 col  input  10  current scan column.
REQ-011 flash_phase  output  2  flash phase to the pattern generator: 00 normal, 01 black, 10 white.
REQ-012 busy  output  1  high from the accepted trigger until the decision.
REQ-013 hit  output  1  one-cycle pulse on a hit.
REQ-014 miss  output  1  one-cycle pulse on a miss.

Function
REQ-015 trigger_raw and light_n SHALL each pass a 2-FF synchronizer; light samples use the synchronized value.
REQ-016 The synchronized trigger SHALL be accepted as pressed only after DEBOUNCE_CYCLES consecutive high cycles; any low cycle restarts the count.
REQ-017 sof SHALL be a single-cycle strobe asserted when row==0 and col==0.
REQ-018 FSM states: IDLE, ARM, BLACK, WHITE, DECIDE, HOLD.
REQ-019 IDLE -> ARM on a debounced press.
REQ-020 ARM -> BLACK on the next sof.
REQ-021 BLACK -> WHITE on the next sof.
REQ-022 WHITE -> DECIDE on the next sof.
REQ-023 DECIDE -> HOLD unconditionally after one cycle.
REQ-024 HOLD -> IDLE only once the debounced trigger is released, so a held trigger never retriggers.
REQ-025 flash_phase SHALL be 01 in BLACK, 10 in WHITE, and 00 otherwise.
REQ-026 busy SHALL be high in ARM, BLACK, WHITE and DECIDE.
REQ-027 dark_cnt SHALL count cycles in BLACK with valid=1 and light_n_sync=0.
REQ-028 lit_cnt SHALL count cycles in WHITE with valid=1 and light_n_sync=0.
REQ-029 dark_cnt and lit_cnt SHALL be 19 bits, saturating at all-ones (no wrap), and cleared on entry to BLACK.
REQ-030 In DECIDE, hit SHALL pulse iff dark_cnt <= DARK_MAX and lit_cnt >= LIGHT_MIN; otherwise miss SHALL pulse; exactly one of the two per shot.
REQ-031 Decision latency SHALL be 1 cycle: the pulse occurs the cycle after the sof that ends WHITE.
REQ-032 Releasing the trigger during ARM, BLACK or WHITE SHALL NOT abort the sequence.
REQ-033 A sof coinciding with the debounce completing SHALL leave the FSM in ARM; BLACK starts at the following sof.
REQ-034 Light samples with valid=0 SHALL be ignored.

Reset
REQ-035 rst_n low SHALL immediately force state IDLE, flash_phase 00, busy/hit/miss 0, counters 0, synchronizers 0, and the debounce count 0, including mid-flash.
REQ-036 Deassertion SHALL be synchronized to clk and take effect on the second clk edge after rst_n rises.

Structure
REQ-037 The state enum, flash_phase encoding and counter width constant SHALL live in shared package duck_hunt_pkg, also used by the pattern generator.
REQ-038 Synchronizer plus debouncer SHALL be one sub-module, sync_debounce, instantiated for the trigger; light_n uses the synchronizer only.

Verification
REQ-039 Test 1: DEBOUNCE_CYCLES=8; press held 7 cycles then released -> no busy, flash_phase stays 00.
REQ-040 Test 2: valid press; light_n=0 for 100 valid pixels in WHITE only -> flash_phase 01 then 10 across 2 frames, single hit pulse, no miss.
REQ-041 Test 3: light_n=0 for 100 pixels in both BLACK and WHITE -> single miss pulse (lamp rejection).
REQ-042 Test 4: lit_cnt=63 with LIGHT_MIN=64 -> miss; lit_cnt=64 -> hit.
REQ-043 Test 5: rst_n pulsed low mid-WHITE -> outputs zero asynchronously, no hit/miss; a new press restarts from ARM.
REQ-044 Test 6: trigger held across three full sequences -> only one hit/miss, FSM parked in HOLD until release.

Source files
------------

// File: rtl/duck_hunt_pkg.sv
// Shared light-gun definitions: shot FSM states, flash phase encoding and
// counter width, used by the hit detector and the pattern generator.
package duck_hunt_pkg;

  localparam int CNT_W = 19;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_BLACK  = 3'd2,
    ST_WHITE  = 3'd3,
    ST_DECIDE = 3'd4,
    ST_HOLD   = 3'd5
  } zap_state_e;

  typedef enum logic [1:0] {
    FLASH_NORMAL = 2'b00,
    FLASH_BLACK  = 2'b01,
    FLASH_WHITE  = 2'b10
  } flash_phase_e;

  function automatic flash_phase_e phase_of(input zap_state_e s);
    case (s)
      ST_BLACK: phase_of = FLASH_BLACK;
      ST_WHITE: phase_of = FLASH_WHITE;
      default:  phase_of = FLASH_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// 2-FF synchronizer followed by a press debouncer: level goes high after
// DEBOUNCE_CYCLES consecutive synchronized high samples, drops on any low.
module sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level_o
);
  import duck_hunt_pkg::*;

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  always_comb begin
    sync_d = {sync_q[0], din};
    cnt_d  = cnt_q;
    db_d   = db_q;
    if (!sync_q[1]) begin
      cnt_d = '0;
      db_d  = 1'b0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      db_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign level_o = db_q;

endmodule

// File: rtl/zapper_hit_detect.sv
// Zapper hit detector: on a debounced trigger, flashes one black and one white
// frame, counts photodiode pixels in each, and pulses hit or miss.
module zapper_hit_detect #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LIGHT_MIN       = 64,
  parameter int DARK_MAX        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trigger_raw,
  input  logic       light_n,
  input  logic       valid,
  input  logic [9:0] row,
  input  logic [9:0] col,
  output logic [1:0] flash_phase,
  output logic       busy,
  output logic       hit,
  output logic       miss
);
  import duck_hunt_pkg::*;

  // Assert asynchronously, release on the second clk edge after rst_n rises.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

  logic trig_db;

  sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_trig (
    .clk     (clk),
    .rst_n   (rst_int_n),
    .din     (trigger_raw),
    .level_o (trig_db)
  );

  logic [1:0] light_sync_q, light_sync_d;
  assign light_sync_d = {light_sync_q[0], light_n};

  zap_state_e       state_q, state_d;
  logic [CNT_W-1:0] dark_cnt_q, dark_cnt_d;
  logic [CNT_W-1:0] lit_cnt_q, lit_cnt_d;
  logic             sof, light_seen, decide_hit;

  assign sof        = (row == 10'd0) && (col == 10'd0);
  assign light_seen = valid && !light_sync_q[1];
  assign decide_hit = (dark_cnt_q <= CNT_W'(DARK_MAX)) && (lit_cnt_q >= CNT_W'(LIGHT_MIN));

  always_comb begin
    state_d    = state_q;
    dark_cnt_d = dark_cnt_q;
    lit_cnt_d  = lit_cnt_q;
    case (state_q)
      ST_IDLE:   if (trig_db) state_d = ST_ARM;
      ST_ARM: begin
        if (sof) begin
          state_d    = ST_BLACK;
          dark_cnt_d = '0;
          lit_cnt_d  = '0;
        end
      end
      ST_BLACK: begin
        if (light_seen && (dark_cnt_q != '1)) dark_cnt_d = dark_cnt_q + CNT_W'(1);
        if (sof) state_d = ST_WHITE;
      end
      ST_WHITE: begin
        if (light_seen && (lit_cnt_q != '1)) lit_cnt_d = lit_cnt_q + CNT_W'(1);
        if (sof) state_d = ST_DECIDE;
      end
      ST_DECIDE: state_d = ST_HOLD;
      // Park here while the trigger is still held so one press is one shot.
      ST_HOLD:   if (!trig_db) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      light_sync_q <= '0;
      state_q      <= ST_IDLE;
      dark_cnt_q   <= '0;
      lit_cnt_q    <= '0;
    end else begin
      light_sync_q <= light_sync_d;
      state_q      <= state_d;
      dark_cnt_q   <= dark_cnt_d;
      lit_cnt_q    <= lit_cnt_d;
    end
  end

  // Outputs decode the state register so reset clears them without a clock.
  assign flash_phase = phase_of(state_q);
  assign busy        = (state_q == ST_ARM) || (state_q == ST_BLACK) ||
                       (state_q == ST_WHITE) || (state_q == ST_DECIDE);
  assign hit         = (state_q == ST_DECIDE) && decide_hit;
  assign miss        = (state_q == ST_DECIDE) && !decide_hit;

endmodule

// File: tb/tb_zapper_hit_detect.sv
// Directed + randomized bench for zapper_hit_detect on a small synthetic
// raster; expected shot outcomes come from pixel counts the bench itself drives.
module tb_zapper_hit_detect;

  localparam int DEB    = 8;
  localparam int LMIN   = 64;
  localparam int DMAX   = 16;
  localparam int COLS   = 20;
  localparam int ROWS   = 12;
  localparam int VCOLS  = 16;
  localparam int VROWS  = 10;
  localparam int FRAME  = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst_n, trigger_raw, light_n, valid;
  logic [9:0] row, col;
  logic [1:0] flash_phase;
  logic       busy, hit, miss;

  int checks = 0;
  int errors = 0;
  int fno = 0;
  int n_hit, n_miss, evt_f, evt_p;

  zapper_hit_detect #(.DEBOUNCE_CYCLES(DEB), .LIGHT_MIN(LMIN), .DARK_MAX(DMAX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trigger_raw (trigger_raw),
    .light_n     (light_n),
    .valid       (valid),
    .row         (row),
    .col         (col),
    .flash_phase (flash_phase),
    .busy        (busy),
    .hit         (hit),
    .miss        (miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One raster frame. trig_len<0 leaves the trigger alone; n_lit photodiode
  // pixels go in rows 2.. cols 0..13, blanking cols 16/17 carry random noise.
  task automatic frame(input int trig_len, input int n_lit, input int rst_at,
                       input int exp_ph, input int exp_busy, input string tag);
    int lit = 0;
    for (int p = 0; p < FRAME; p++) begin
      int r, c;
      r = p / COLS;
      c = p % COLS;
      row   = 10'(r);
      col   = 10'(c);
      valid = (r < VROWS) && (c < VCOLS);
      if (trig_len >= 0) trigger_raw = (p < trig_len);
      light_n = 1'b1;
      if (r >= 2 && r < VROWS && c <= 13 && lit < n_lit) begin
        light_n = 1'b0;
        lit++;
      end else if (c == 16 || c == 17) begin
        light_n = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      end
      if (p == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, " rst phase"}, int'(flash_phase), 0);
        chk({tag, " rst busy"},  int'(busy), 0);
        chk({tag, " rst hitmiss"}, int'(hit | miss), 0);
      end
      if (rst_at >= 0 && p == rst_at + 4) rst_n = 1'b1;
      @(posedge clk);
      #1;
      if (hit)  begin n_hit++;  evt_f = fno; evt_p = p; end
      if (miss) begin n_miss++; evt_f = fno; evt_p = p; end
      if (p == FRAME / 2) begin
        chk({tag, " phase"}, int'(flash_phase), exp_ph);
        chk({tag, " busy"},  int'(busy), exp_busy);
      end
    end
    fno++;
  endtask

  task automatic clr_evt();
    n_hit = 0; n_miss = 0; evt_f = -1; evt_p = -1;
  endtask

  task automatic shot(input int nb, input int nw, input bit rel_early, input string tag);
    bit exp_hit;
    int dframe;
    exp_hit = (nb <= DMAX) && (nw >= LMIN);
    clr_evt();
    frame(FRAME, 0, -1, 0, 1, {tag, " arm"});
    frame(rel_early ? 0 : FRAME, nb, -1, 1, 1, {tag, " black"});
    frame(rel_early ? 0 : FRAME, nw, -1, 2, 1, {tag, " white"});
    dframe = fno;
    frame(0, 0, -1, 0, 0, {tag, " post"});
    chk({tag, " hits"},   n_hit,  exp_hit ? 1 : 0);
    chk({tag, " misses"}, n_miss, exp_hit ? 0 : 1);
    chk({tag, " evt frame"}, evt_f, dframe);
    chk({tag, " evt pixel"}, evt_p, 0);
  endtask

  initial begin
    rst_n = 1'b0; trigger_raw = 1'b0; light_n = 1'b1; valid = 1'b0;
    row = 10'd5; col = 10'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("reset phase", int'(flash_phase), 0);
    chk("reset busy",  int'(busy), 0);
    chk("reset hitmiss", int'(hit | miss), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Short press one cycle below the debounce time.
    clr_evt();
    frame(DEB - 1, 0, -1, 0, 0, "t1 short");
    frame(0, 0, -1, 0, 0, "t1 after");
    chk("t1 events", n_hit + n_miss, 0);

    shot(0, 100, 1'b0, "t2 hit");
    shot(100, 100, 1'b0, "t3 lamp");
    shot(0, LMIN - 1, 1'b0, "t4 lit63");
    shot(0, LMIN, 1'b1, "t4 lit64");
    shot(DMAX, 100, 1'b0, "dark16");
    shot(DMAX + 1, 100, 1'b1, "dark17");

    // Reset in the middle of the white frame, trigger released.
    clr_evt();
    frame(FRAME, 0, -1, 0, 1, "t5 arm");
    frame(FRAME, 0, -1, 1, 1, "t5 black");
    frame(0, 100, 40, 0, 0, "t5 white");
    frame(0, 0, -1, 0, 0, "t5 post");
    chk("t5 events", n_hit + n_miss, 0);
    shot(0, 100, 1'b0, "t5 again");

    // Trigger held across several sequence lengths.
    clr_evt();
    frame(FRAME, 0, -1, 0, 1, "t6 arm");
    frame(FRAME, 0, -1, 1, 1, "t6 black");
    frame(FRAME, 100, -1, 2, 1, "t6 white");
    for (int i = 0; i < 7; i++) frame(FRAME, 100, -1, 0, 0, "t6 held");
    chk("t6 hits", n_hit, 1);
    chk("t6 misses", n_miss, 0);
    frame(0, 0, -1, 0, 0, "t6 release");
    shot(5, 90, 1'b0, "t6 next");

    for (int i = 0; i < 8; i++) begin
      int nb, nw;
      bit rel;
      nb  = int'($urandom_range(0, 30));
      nw  = int'($urandom_range(50, 112));
      rel = 1'($urandom_range(0, 1));
      shot(nb, nw, rel, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
